// File: rtl/fp_pkg.sv
// Shared single-precision add/sub types, constants and flag packing.
// Used by the sequencer and its rounding stage.
package fp_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam int          SIG_W   = 27;

   localparam int FLG_INVALID   = 4;
   localparam int FLG_OVERFLOW  = 3;
   localparam int FLG_UNDERFLOW = 2;
   localparam int FLG_INEXACT   = 1;
   localparam int FLG_ZERO      = 0;

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
   } fp_seq_state_e;

   function automatic logic [4:0] mk_flags(input logic inv, input logic ovf,
                                           input logic unf, input logic inx,
                                           input logic zro);
      logic [4:0] f;
      f                = '0;
      f[FLG_INVALID]   = inv;
      f[FLG_OVERFLOW]  = ovf;
      f[FLG_UNDERFLOW] = unf;
      f[FLG_INEXACT]   = inx;
      f[FLG_ZERO]      = zro;
      return f;
   endfunction

endpackage

// File: rtl/fp_normalize.sv
// Combinational normalize stage: right-shift by one on carry, otherwise
// left-shift out leading zeros without taking the exponent below 1.
module fp_normalize #(
   parameter int SIG_W = 27
) (
   input  logic [SIG_W-1:0] sig,
   input  logic             carry,
   input  logic [7:0]       exp,
   output logic [SIG_W-1:0] sig_norm,
   output logic [7:0]       shift
);

   localparam logic [7:0] SIG_W8 = 8'(SIG_W);

   logic [7:0] lz;
   logic [7:0] lim;
   logic [7:0] sh;

   always_comb begin
      lz = SIG_W8;
      for (int i = 0; i < SIG_W; i++)
         if (sig[i]) lz = 8'(SIG_W - 1 - i);
      lim = exp - 8'd1;
      sh  = (lz < lim) ? lz : lim;
      if (carry) begin
         sig_norm = {1'b1, sig[SIG_W-1:1]} | {{(SIG_W-1){1'b0}}, sig[0]};
         shift    = 8'd1;
      end else begin
         sig_norm = sig << sh;
         shift    = 8'd0 - sh;
      end
   end

endmodule

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on the G/R/S tail of a normalized significand,
// producing the packed exponent/fraction fields and rounding status.
module fp_round_rne
   import fp_pkg::*;
#(
   parameter int SIG_W = 27
) (
   input  logic [SIG_W-1:0] sig_norm,
   input  logic [7:0]       exp,
   output logic [7:0]       exp_out,
   output logic [22:0]      frac_out,
   output logic             overflow,
   output logic             inexact,
   output logic             tiny,
   output logic             is_zero
);

   localparam int LSB = SIG_W - 24;

   logic [23:0] mant;
   logic        guard;
   logic        rest;
   logic        up;
   logic [24:0] mant_r;
   logic [8:0]  exp9;

   always_comb begin
      mant     = sig_norm[SIG_W-1:LSB];
      guard    = sig_norm[LSB-1];
      rest     = |sig_norm[LSB-2:0];
      inexact  = guard | rest;
      up       = guard & (rest | mant[0]);
      mant_r   = {1'b0, mant} + {24'd0, up};
      exp9     = {1'b0, exp} + {8'd0, mant_r[24]};
      is_zero  = (mant_r == 25'd0);
      tiny     = ~sig_norm[SIG_W-1];
      overflow = (exp9 >= 9'd255);
      frac_out = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
      // no hidden bit after rounding means a denormal: exponent field is 0
      exp_out  = (mant_r[24] | mant_r[23]) ? exp9[7:0] : 8'd0;
      if (overflow) begin
         exp_out  = EXP_MAX;
         frac_out = '0;
      end
   end

endmodule

// File: rtl/fp_addsub_seq_ctrl.sv
// Multi-cycle single-precision add/sub sequencer, one operation in flight:
// accept, unpack, align, add, normalize, round, hold result until taken.
module fp_addsub_seq_ctrl
   import fp_pkg::*;
#(
   parameter int ALIGN_STEP = 4,
   parameter int SIG_W      = 27
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        op_sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [4:0]  flags
);

   localparam logic [7:0] STEP   = 8'(ALIGN_STEP);
   localparam logic [7:0] SIG_W8 = 8'(SIG_W);
   localparam int         PAD    = SIG_W - 24;

   fp_seq_state_e    state;
   fp32_t            a_l, b_l;
   logic             sub_l;
   logic             sign_r, eff_sub, carry_r;
   logic [7:0]       exp_r, diff;
   logic [SIG_W-1:0] sig_a, sig_b;

   // operand decode, only meaningful in UNPACK
   logic             b_eff, a_nan, b_nan, a_inf, b_inf, swap;
   logic [7:0]       ea, eb, diff_u;
   logic [SIG_W-1:0] siga_u, sigb_u;

   always_comb begin
      b_eff  = b_l.sign ^ sub_l;
      a_nan  = (a_l.exp == EXP_MAX) && (a_l.frac != '0);
      b_nan  = (b_l.exp == EXP_MAX) && (b_l.frac != '0);
      a_inf  = (a_l.exp == EXP_MAX) && (a_l.frac == '0);
      b_inf  = (b_l.exp == EXP_MAX) && (b_l.frac == '0);
      ea     = (a_l.exp == 8'd0) ? 8'd1 : a_l.exp;
      eb     = (b_l.exp == 8'd0) ? 8'd1 : b_l.exp;
      siga_u = {(a_l.exp != 8'd0), a_l.frac, {PAD{1'b0}}};
      sigb_u = {(b_l.exp != 8'd0), b_l.frac, {PAD{1'b0}}};
      swap   = {b_l.exp, b_l.frac} > {a_l.exp, a_l.frac};
      diff_u = swap ? (eb - ea) : (ea - eb);
   end

   logic [7:0]       step;
   logic [SIG_W-1:0] b_shift;

   always_comb begin
      step    = (diff < STEP) ? diff : STEP;
      b_shift = (sig_b >> step) |
                {{(SIG_W-1){1'b0}}, |(sig_b & ~({SIG_W{1'b1}} << step))};
   end

   logic [SIG_W-1:0] sig_norm;
   logic [7:0]       norm_shift;

   fp_normalize #(.SIG_W(SIG_W)) u_norm (
      .sig      (sig_a),
      .carry    (carry_r),
      .exp      (exp_r),
      .sig_norm (sig_norm),
      .shift    (norm_shift)
   );

   logic [7:0]  r_exp;
   logic [22:0] r_frac;
   logic        r_ovf, r_inx, r_tiny, r_zero;

   fp_round_rne #(.SIG_W(SIG_W)) u_round (
      .sig_norm (sig_a),
      .exp      (exp_r),
      .exp_out  (r_exp),
      .frac_out (r_frac),
      .overflow (r_ovf),
      .inexact  (r_inx),
      .tiny     (r_tiny),
      .is_zero  (r_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
         a_l       <= '0;
         b_l       <= '0;
         sub_l     <= 1'b0;
         sign_r    <= 1'b0;
         eff_sub   <= 1'b0;
         carry_r   <= 1'b0;
         exp_r     <= '0;
         diff      <= '0;
         sig_a     <= '0;
         sig_b     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  a_l      <= op_a;
                  b_l      <= op_b;
                  sub_l    <= op_sub;
                  in_ready <= 1'b0;
                  state    <= S_UNPACK;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            S_UNPACK: begin
               if (a_nan || b_nan || (a_inf && b_inf && (a_l.sign != b_eff))) begin
                  result    <= FP_QNAN;
                  flags     <= mk_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else if (a_inf || b_inf) begin
                  result    <= a_inf ? a_l : {b_eff, b_l.exp, b_l.frac};
                  flags     <= '0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  sign_r  <= swap ? b_eff : a_l.sign;
                  eff_sub <= a_l.sign ^ b_eff;
                  exp_r   <= swap ? eb : ea;
                  sig_a   <= swap ? sigb_u : siga_u;
                  sig_b   <= swap ? siga_u : sigb_u;
                  diff    <= diff_u;
                  state   <= (diff_u == 8'd0) ? S_ADD : S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (diff >= SIG_W8) begin
                  sig_b <= {{(SIG_W-1){1'b0}}, |sig_b};
                  diff  <= '0;
                  state <= S_ADD;
               end else begin
                  sig_b <= b_shift;
                  diff  <= diff - step;
                  if (diff <= STEP) state <= S_ADD;
               end
            end
            S_ADD: begin
               // operands are ordered, so subtraction never goes negative
               {carry_r, sig_a} <= eff_sub ? ({1'b0, sig_a} - {1'b0, sig_b})
                                           : ({1'b0, sig_a} + {1'b0, sig_b});
               state <= S_NORM;
            end
            S_NORM: begin
               sig_a <= sig_norm;
               exp_r <= exp_r + norm_shift;
               state <= S_ROUND;
            end
            S_ROUND: begin
               if (r_ovf) begin
                  result <= {sign_r, EXP_MAX, 23'd0};
                  flags  <= mk_flags(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
               end else if (r_zero) begin
                  result <= {sign_r & ~eff_sub, 31'd0};
                  flags  <= mk_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
               end else begin
                  result <= {sign_r, r_exp, r_frac};
                  flags  <= mk_flags(1'b0, 1'b0, r_tiny & r_inx, r_inx, 1'b0);
               end
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_seq_ctrl.sv
// Scoreboard bench for the add/sub sequencer: a driver queues expected
// results, a monitor checks result, flags and latency at each handshake.
module tb_fp_addsub_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        op_sub = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        in_ready, out_valid;
   logic [31:0] result;
   logic [4:0]  flags;

   always #5 clk = ~clk;

   fp_addsub_seq_ctrl #(.ALIGN_STEP(4), .SIG_W(27)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) acc_cyc <= cyc;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // monitor: latency measured from accept edge to first out_valid cycle
   initial begin : monitor
      logic ov_prev;
      int   lat;
      exp_t e;
      ov_prev = 1'b0;
      lat     = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ov_prev = 1'b0;
         end else begin
            if (out_valid && !ov_prev) lat = cyc - acc_cyc;
            ov_prev = out_valid;
            if (out_valid && out_ready) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: result %h flags %h with nothing pending",
                           result, flags);
               end else begin
                  e = sbq.pop_front();
                  chk({e.name, "_result"}, result, e.res);
                  chk({e.name, "_flags"}, {27'd0, flags}, {27'd0, e.flg});
                  chk({e.name, "_latency"}, 32'(lat), 32'(e.lat));
               end
            end
         end
      end
   end

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_idle: in_ready=%b after %0d cycles, expected 1", nm, in_ready, n);
      end
   endtask

   task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] r, input logic [4:0] f,
                        input int lat, input bit push);
      wait_idle(nm);
      if (in_ready) begin
         op_a     = a;
         op_b     = b;
         op_sub   = sub;
         in_valid = 1'b1;
         if (push) sbq.push_back('{res: r, flg: f, lat: lat, name: nm});
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   initial begin : stim
      int n;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_flags", {27'd0, flags}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

      //     name       op_a          op_b          sub   result        flags  lat
      issue("one_p_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'h00, 5,  1);
      issue("one_m_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 5'h01, 5,  1);
      issue("tie_small", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 5'h02, 11, 1);
      issue("tie_big",   32'h3F800000, 32'h4B800000, 1'b0, 32'h4B800000, 5'h02, 11, 1);
      issue("inf_m_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 5'h10, 2,  1);
      issue("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5'h0A, 5,  1);
      issue("two_m_one", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 5'h00, 6,  1);
      issue("one_m_two", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 5'h00, 6,  1);
      issue("inf_p_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 5'h00, 2,  1);
      issue("nan_in",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'h10, 2,  1);
      issue("far_denorm",32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 5'h02, 6,  1);
      issue("denorms",   32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 5'h00, 5,  1);

      // backpressure: result must hold while out_ready is low
      wait_idle("stall");
      out_ready = 1'b0;
      issue("stall", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 5'h00, 6, 1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_result", result, 32'h40800000);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;

      // reset while the long alignment is in progress
      issue("abort", 32'h3F800000, 32'h4B800000, 1'b0, 32'h0, 5'h00, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_idle_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (20) @(negedge clk);

      issue("after_abort", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'h00, 5, 1);

      n = 0;
      while ((sbq.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d results still pending, expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
